// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver on a 16x oversample strobe, with a valid/ready holding register.
// Byte and error pulses register one clk after the stop-sample tick; a full register drops new bytes (overrun).
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 rx_s;
  logic                 handshake;
  logic                 deliver;

  assign rx_s      = sync_q[1];
  assign handshake = valid_q & rx_ready;

  always_comb begin
    sync_d  = {sync_q[0], rx};
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    deliver = 1'b0;

    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            // First bit received drifts down to bit 0 (LSB first on the wire).
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = S_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            bcnt_d = '0;
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            if (rx_s) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end
      endcase
    end

    if (handshake) begin
      valid_d = 1'b0;
    end
    // A consumer handshake in the delivery cycle frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || handshake) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign overrun_error = ov_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: table of good frames plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun_error;
  logic       busy;

  uart_rx_oversample dut (
    .clk           (clk),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tick_div = 3;
  int tick_cnt = 0;
  int tick_no  = 0;
  int n_checks = 0;
  int n_err    = 0;

  int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0, rise_tick = -1;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_valid = 1'b0;
  logic [7:0] acc_q[$];

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_cnt >= tick_div) begin
        baud_tick = 1'b1;
        tick_cnt  = 0;
      end else begin
        baud_tick = 1'b0;
        tick_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (baud_tick) tick_no <= tick_no + 1;
  end

  // Observer: accepted bytes, error pulse counts and widths, valid rise time.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (framing_error) fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (framing_error && prev_fe) fe_wide++;
      if (overrun_error && prev_ov) ov_wide++;
      if (rx_valid && !prev_valid) rise_tick = tick_no;
      prev_fe    = framing_error;
      prev_ov    = overrun_error;
      prev_valid = rx_valid;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_no + n;
    while (tick_no < target) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      wait_ticks(16);
    end
    rx = stop_bit;
    wait_ticks(16);
  endtask

  task automatic ready_pulse();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, fe0, ov0;

    vecs[0] = '{data: 8'h01, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h01};
    vecs[1] = '{data: 8'h80, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h80};
    vecs[2] = '{data: 8'hFF, ready: 1'b1, exp_valid: 1'b0, exp_data: 8'hFF};
    vecs[3] = '{data: 8'h5A, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h5A};
    vecs[4] = '{data: 8'h96, ready: 1'b1, exp_valid: 1'b0, exp_data: 8'h96};
    vecs[5] = '{data: 8'h6D, ready: 1'b0, exp_valid: 1'b1, exp_data: 8'h6D};

    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    #2;
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_framing", 32'(framing_error), 0);
    chk("reset_overrun", 32'(overrun_error), 0);
    chk("reset_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(8);

    // Good frame with exact delivery timing.
    fe0 = fe_cnt; ov0 = ov_cnt;
    base = tick_no;
    send_frame(8'hA5, 1'b1);
    chk("good_valid", 32'(rx_valid), 1);
    chk("good_data", 32'(rx_data), 'hA5);
    chk("good_rise_tick", 32'(rise_tick - base), 153);
    chk("good_no_fe", 32'(fe_cnt - fe0), 0);
    chk("good_busy_after", 32'(busy), 0);
    ready_pulse();
    chk("good_valid_drop", 32'(rx_valid), 0);
    wait_ticks(4);

    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_ready = vecs[i].ready;
      acc_q.delete();
      send_frame(vecs[i].data, 1'b1);
      wait_ticks(2);
      chk($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
        ready_pulse();
        chk($sformatf("vec%0d_valid_drop", i), 32'(rx_valid), 0);
      end
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
      if (acc_q.size() > 0)
        chk($sformatf("vec%0d_accepted", i), 32'(acc_q[acc_q.size()-1]), 32'(vecs[i].exp_data));
      else
        chk($sformatf("vec%0d_accepted_count", i), 0, 1);
      chk($sformatf("vec%0d_errors", i), 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
      wait_ticks(4);
    end

    // False start: 4 ticks low, START samples high at detection+8.
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(4);
    chk("false_busy_t8", 32'(busy), 1);
    wait_ticks(1);
    chk("false_busy_t9", 32'(busy), 0);
    wait_ticks(20);
    chk("false_valid", 32'(rx_valid), 0);
    chk("false_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

    // Framing error then break held low.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    chk("fe_count", 32'(fe_cnt - fe0), 1);
    chk("fe_valid", 32'(rx_valid), 0);
    chk("fe_busy_break", 32'(busy), 1);
    rx = 1'b1;
    wait_ticks(4);
    chk("fe_busy_released", 32'(busy), 0);
    send_frame(8'h5A, 1'b1);
    chk("fe_next_valid", 32'(rx_valid), 1);
    chk("fe_next_data", 32'(rx_data), 'h5A);
    ready_pulse();
    wait_ticks(4);

    // Overrun, then delivery coinciding with a handshake.
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    wait_ticks(4);
    send_frame(8'h22, 1'b1);
    wait_ticks(2);
    chk("ovr_count", 32'(ov_cnt - ov0), 1);
    chk("ovr_data_kept", 32'(rx_data), 'h11);
    chk("ovr_valid", 32'(rx_valid), 1);
    acc_q.delete();
    base = tick_no;
    fork
      send_frame(8'h33, 1'b1);
      begin
        while (tick_no < base + 152) @(negedge clk);
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    chk("coinc_valid", 32'(rx_valid), 1);
    chk("coinc_data", 32'(rx_data), 'h33);
    chk("coinc_no_overrun", 32'(ov_cnt - ov0), 1);
    chk("coinc_accepted_n", 32'(acc_q.size()), 1);
    if (acc_q.size() > 0) chk("coinc_accepted_old", 32'(acc_q[0]), 'h11);
    ready_pulse();
    chk("ovr_valid_drop", 32'(rx_valid), 0);
    wait_ticks(4);

    // Back-to-back frames, ready tied high, at two tick rates.
    for (int r = 0; r < 2; r++) begin
      tick_div = (r == 0) ? 3 : 0;
      wait_ticks(4);
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_ready = 1'b1;
      acc_q.delete();
      send_frame((r == 0) ? 8'h00 : 8'h0F, 1'b1);
      send_frame((r == 0) ? 8'hFF : 8'hF0, 1'b1);
      wait_ticks(4);
      chk($sformatf("b2b%0d_count", r), 32'(acc_q.size()), 2);
      if (acc_q.size() >= 2) begin
        chk($sformatf("b2b%0d_first", r), 32'(acc_q[0]), (r == 0) ? 'h00 : 'h0F);
        chk($sformatf("b2b%0d_second", r), 32'(acc_q[1]), (r == 0) ? 'hFF : 'hF0);
      end
      chk($sformatf("b2b%0d_errors", r), 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
      rx_ready = 1'b0;
    end
    tick_div = 3;
    wait_ticks(4);

    // Reset in the middle of data bit 3 with a byte pending.
    send_frame(8'h96, 1'b1);
    chk("rst_pre_valid", 32'(rx_valid), 1);
    wait_ticks(4);
    rx = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 3; b++) begin
      rx = b[0];
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    chk("rst_pre_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_data", 32'(rx_data), 0);
    chk("rst_mid_valid", 32'(rx_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_flags", 32'({framing_error, overrun_error}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ticks(8);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hC3, 1'b1);
    chk("rst_after_valid", 32'(rx_valid), 1);
    chk("rst_after_data", 32'(rx_data), 'hC3);
    chk("rst_after_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

    chk("fe_pulse_width", 32'(fe_wide), 0);
    chk("ovr_pulse_width", 32'(ov_wide), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
